// File: rtl/synch_fifo_pkg.sv
// -----------------------------------------------------------------------------
// synch_fifo_pkg
// Shared constants and helpers for the synchronous FIFO slice.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF / FIFO_PTR_DEF : default geometry
//   ptr_width()                                    : ceil(log2(depth))
// No ports.
// -----------------------------------------------------------------------------
package synch_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_PTR_DEF   = 4;

  // Smallest w such that 2**w >= depth; used to cross-check DEPTH against PTR.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/synch_fifo_if.sv
// -----------------------------------------------------------------------------
// synch_fifo_if
// Handshake/data bundle between a FIFO user (master) and the FIFO (slave).
//   fifo_wren, fifo_rden, fifo_wrdata          : master -> FIFO
//   fifo_rddata, fifo_full, fifo_empty,
//   fifo_room_avail, fifo_data_avail           : FIFO -> master
//   fifo_overflow, fifo_underflow              : FIFO -> master, only when
//                                                FIFO_ERR_FLAG_EN is defined
// -----------------------------------------------------------------------------
interface synch_fifo_if
  import synch_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_PTR   = FIFO_PTR_DEF
);

  logic                  fifo_wren;
  logic                  fifo_rden;
  logic [FIFO_WIDTH-1:0] fifo_wrdata;
  logic [FIFO_WIDTH-1:0] fifo_rddata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_PTR:0]     fifo_room_avail;
  logic [FIFO_PTR:0]     fifo_data_avail;
`ifdef FIFO_ERR_FLAG_EN
  logic                  fifo_overflow;
  logic                  fifo_underflow;
`endif

`ifdef FIFO_ERR_FLAG_EN
  modport master (
    output fifo_wren, fifo_rden, fifo_wrdata,
    input  fifo_rddata, fifo_full, fifo_empty, fifo_room_avail, fifo_data_avail,
    input  fifo_overflow, fifo_underflow
  );
  modport slave (
    input  fifo_wren, fifo_rden, fifo_wrdata,
    output fifo_rddata, fifo_full, fifo_empty, fifo_room_avail, fifo_data_avail,
    output fifo_overflow, fifo_underflow
  );
`else
  modport master (
    output fifo_wren, fifo_rden, fifo_wrdata,
    input  fifo_rddata, fifo_full, fifo_empty, fifo_room_avail, fifo_data_avail
  );
  modport slave (
    input  fifo_wren, fifo_rden, fifo_wrdata,
    output fifo_rddata, fifo_full, fifo_empty, fifo_room_avail, fifo_data_avail
  );
`endif

endinterface

// File: rtl/synch_fifo_mem.sv
// -----------------------------------------------------------------------------
// synch_fifo_mem
// FIFO_DEPTH x FIFO_WIDTH register array, one write port, one synchronous
// read port. The array itself is not reset; only the read register is.
//   clk, rst_n            : clock, synchronous active-low reset
//   i_wr_en, i_wr_addr,
//   i_wr_data             : write port
//   i_rd_en, i_rd_addr    : read port (data registered on the same edge)
//   o_rd_data             : registered read data, holds when i_rd_en is low
// -----------------------------------------------------------------------------
module synch_fifo_mem
  import synch_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_PTR   = FIFO_PTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [FIFO_PTR-1:0]   i_wr_addr,
  input  logic [FIFO_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [FIFO_PTR-1:0]   i_rd_addr,
  output logic [FIFO_WIDTH-1:0] o_rd_data
);

  logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [FIFO_WIDTH-1:0] r_rd_data;

  // Storage write; left unreset so it can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register: cleared by reset, loaded only on an accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= {FIFO_WIDTH{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/synch_fifo.sv
// -----------------------------------------------------------------------------
// synch_fifo
// Single-clock FIFO with registered read data and occupancy/room counters.
// Writes when full and reads when empty are dropped.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, priority over all requests
//   bus    : synch_fifo_if.slave (wren/rden/wrdata in; rddata, full, empty,
//            room_avail, data_avail out)
// Optional build macro FIFO_ERR_FLAG_EN adds sticky fifo_overflow /
// fifo_underflow outputs on the interface, cleared only by reset.
// -----------------------------------------------------------------------------
module synch_fifo
  import synch_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_PTR   = FIFO_PTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  synch_fifo_if.slave bus
);

  // Reject geometries where DEPTH is not exactly 2**PTR.
  if ((FIFO_DEPTH != (1 << FIFO_PTR)) || (ptr_width(FIFO_DEPTH) != FIFO_PTR)) begin : g_cfg_err
    $error("synch_fifo: FIFO_DEPTH must equal 2**FIFO_PTR");
  end

  localparam logic [FIFO_PTR:0] DEPTH_W = (FIFO_PTR + 1)'(FIFO_DEPTH);

  logic [FIFO_PTR-1:0] r_wr_ptr;
  logic [FIFO_PTR-1:0] r_rd_ptr;
  logic [FIFO_PTR:0]   r_count;
  logic [FIFO_PTR:0]   r_room;
  logic                r_full;
  logic                r_empty;
  logic [FIFO_PTR:0]   w_count_nxt;
  logic                w_wr_ok;
  logic                w_rd_ok;

  // Acceptance uses the flags of the current registered state.
  assign w_wr_ok = bus.fifo_wren & ~r_full;
  assign w_rd_ok = bus.fifo_rden & ~r_empty;

  // Next occupancy; a simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_rd_ok && !w_wr_ok) begin
      w_count_nxt = r_count - 1'b1;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Pointers, occupancy and status flags. Flags are decoded from the next
  // occupancy so they are registered yet track r_count exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {FIFO_PTR{1'b0}};
      r_rd_ptr <= {FIFO_PTR{1'b0}};
      r_count  <= {(FIFO_PTR + 1){1'b0}};
      r_room   <= DEPTH_W;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_room  <= DEPTH_W - w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_W);
      r_empty <= (w_count_nxt == {(FIFO_PTR + 1){1'b0}});
    end
  end

  synch_fifo_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_PTR   (FIFO_PTR)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.fifo_wrdata),
    .i_rd_en   (w_rd_ok),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (bus.fifo_rddata)
  );

  assign bus.fifo_full       = r_full;
  assign bus.fifo_empty      = r_empty;
  assign bus.fifo_data_avail = r_count;
  assign bus.fifo_room_avail = r_room;

`ifdef FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags: any request hitting a full/empty FIFO latches until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (bus.fifo_wren & r_full);
      r_underflow <= r_underflow | (bus.fifo_rden & r_empty);
    end
  end

  assign bus.fifo_overflow  = r_overflow;
  assign bus.fifo_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_synch_fifo.sv
// -----------------------------------------------------------------------------
// tb_synch_fifo
// Directed plus randomised check of synch_fifo against a queue reference.
// -----------------------------------------------------------------------------
module tb_synch_fifo;
  import synch_fifo_pkg::*;

  localparam int W = 32;
  localparam int P = 4;
  localparam int D = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  synch_fifo_if #(.FIFO_WIDTH(W), .FIFO_PTR(P)) bus ();

  synch_fifo #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D),
    .FIFO_PTR   (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] q[$];
  int           m_count;
  logic [W-1:0] m_rd;
  logic         m_ovf;
  logic         m_udf;
  logic [W-1:0] words [0:31];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_avail", W'(bus.fifo_data_avail), W'(m_count));
    chk("room_avail", W'(bus.fifo_room_avail), W'(D - m_count));
    chk("full",       W'(bus.fifo_full),       W'(m_count == D));
    chk("empty",      W'(bus.fifo_empty),      W'(m_count == 0));
    chk("rddata",     bus.fifo_rddata,         m_rd);
    chk("avail_sum",  W'(bus.fifo_data_avail) + W'(bus.fifo_room_avail), W'(D));
`ifdef FIFO_ERR_FLAG_EN
    chk("overflow",   W'(bus.fifo_overflow),   W'(m_ovf));
    chk("underflow",  W'(bus.fifo_underflow),  W'(m_udf));
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input logic rst, input logic wr, input logic rd, input logic [W-1:0] d);
    logic wr_ok;
    logic rd_ok;
    rst_n           = ~rst;
    bus.fifo_wren   = wr;
    bus.fifo_rden   = rd;
    bus.fifo_wrdata = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      wr_ok = wr && (m_count < D);
      rd_ok = rd && (m_count > 0);
      if (wr && (m_count == D)) m_ovf = 1'b1;
      if (rd && (m_count == 0)) m_udf = 1'b1;
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    m_count = q.size();
    #1;
    check_all();
  endtask

  initial begin
    m_count = 0;
    m_rd    = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    bus.fifo_wren   = 1'b0;
    bus.fifo_rden   = 1'b0;
    bus.fifo_wrdata = '0;

    // Reset held for 5 cycles, then released
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("rst_empty", W'(bus.fifo_empty), 32'd1);
    chk("rst_full",  W'(bus.fifo_full),  32'd0);
    chk("rst_avail", W'(bus.fifo_data_avail), 32'd0);
    chk("rst_room",  W'(bus.fifo_room_avail), 32'd16);
    chk("rst_rd",    bus.fifo_rddata, 32'd0);

    // Fill: 17 writes, the last one is dropped
    for (int i = 0; i < 17; i++) begin
      words[i] = $urandom;
      cyc(1'b0, 1'b1, 1'b0, words[i]);
    end
    chk("fill_full",  W'(bus.fifo_full),       32'd1);
    chk("fill_avail", W'(bus.fifo_data_avail), 32'd16);
    chk("fill_room",  W'(bus.fifo_room_avail), 32'd0);

    // Half drain: 8 reads return words 0..7 in order
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, '0);
      chk("drain_rd", bus.fifo_rddata, words[i]);
    end
    chk("drain_avail", W'(bus.fifo_data_avail), 32'd8);
    chk("drain_room",  W'(bus.fifo_room_avail), 32'd8);
    chk("drain_full",  W'(bus.fifo_full),       32'd0);

    // Wrap: 8 more writes, then 16 reads across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      words[17 + i] = $urandom;
      cyc(1'b0, 1'b1, 1'b0, words[17 + i]);
    end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, '0);
      chk("wrap_rd", bus.fifo_rddata, (i < 8) ? words[8 + i] : words[9 + i]);
    end
    chk("wrap_empty", W'(bus.fifo_empty),      32'd1);
    chk("wrap_avail", W'(bus.fifo_data_avail), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, '0);
      chk("extra_rd_hold", bus.fifo_rddata, words[24]);
    end

    // Simultaneous at occupancy 8
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 32'hA000_0000 + i);
    cyc(1'b0, 1'b1, 1'b1, 32'hB000_0000);
    chk("sim8_avail", W'(bus.fifo_data_avail), 32'd8);
    chk("sim8_rd",    bus.fifo_rddata, 32'hA000_0000);
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1, '0);
      chk("sim8_drain", bus.fifo_rddata, 32'hA000_0000 + i);
    end
    cyc(1'b0, 1'b0, 1'b1, '0);
    chk("sim8_last", bus.fifo_rddata, 32'hB000_0000);

    // Simultaneous at empty: only the write lands
    cyc(1'b0, 1'b1, 1'b1, 32'hC000_0000);
    chk("sim0_avail", W'(bus.fifo_data_avail), 32'd1);
    chk("sim0_rd",    bus.fifo_rddata, 32'hB000_0000);

    // Simultaneous at full: only the read lands
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 32'hC000_0000 + i);
    chk("simF_full", W'(bus.fifo_full), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("simF_avail", W'(bus.fifo_data_avail), 32'd15);
    chk("simF_rd",    bus.fifo_rddata, 32'hC000_0000);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, '0);
      chk("simF_drain", bus.fifo_rddata, 32'hC000_0000 + i);
    end
    chk("simF_empty", W'(bus.fifo_empty), 32'd1);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 1000; i++) begin
      cyc((i == 500) || (i == 501), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if (i == 501) begin
        chk("mid_rst_empty", W'(bus.fifo_empty),      32'd1);
        chk("mid_rst_room",  W'(bus.fifo_room_avail), 32'd16);
        chk("mid_rst_rd",    bus.fifo_rddata,         32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
